// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
// Bundles the signals around the instruction-fetch stage: the PC and hazard
// controls coming in, the IROM address/data pair, and the IF/ID bundle
// going out.
//
//   pc          current PC from the PC register
//   stall       hazard stall (PC register holds pc during stall)
//   flush       branch/jump redirect, squashes the in-flight fetch
//   irom_addr   IROM word address (combinational from pc)
//   irom_rdata  IROM data, valid one cycle after irom_addr
//   id_pc       pc of the presented instruction
//   id_pc4      id_pc + 4, wrapping
//   id_inst     presented instruction (NOP when id_valid = 0)
//   id_valid    presented instruction is real, not a bubble
//
// Modports:
//   master  the environment (PC register, hazard unit, IROM, IF/ID consumer)
//   slave   the fetch stage itself
// ---------------------------------------------------------------------------
interface if_fetch_stage_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [31:0]       pc;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] irom_addr;
    logic [31:0]       irom_rdata;
    logic [31:0]       id_pc;
    logic [31:0]       id_pc4;
    logic [31:0]       id_inst;
    logic              id_valid;

    modport master (
        output pc,
        output stall,
        output flush,
        input  irom_addr,
        output irom_rdata,
        input  id_pc,
        input  id_pc4,
        input  id_inst,
        input  id_valid
    );

    modport slave (
        input  pc,
        input  stall,
        input  flush,
        output irom_addr,
        input  irom_rdata,
        output id_pc,
        output id_pc4,
        output id_inst,
        output id_valid
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage sitting right after the PC register. It addresses
// a synchronous IROM from the current pc, pairs the one-cycle-late ROM data
// with the pc that requested it, and presents {pc, pc+4, inst} to IF/ID.
// A stalled instruction is preserved in a hold register; a flush turns the
// next cycle into a single bubble.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   bus (slave)     pc / stall / flush in, irom_addr out, irom_rdata in,
//                   id_pc / id_pc4 / id_inst / id_valid out
//   perf_fetch      (IF_PERF_CNT_EN only) count of unstalled, unflushed cycles
//   perf_stall      (IF_PERF_CNT_EN only) count of stall cycles without flush
//   perf_flush      (IF_PERF_CNT_EN only) count of flush cycles
//
// Optional feature macro: IF_PERF_CNT_EN adds three 32-bit wrapping
// performance counters and their output ports.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int unsigned ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_stage_if.slave bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_flush
`endif
);

    logic [31:0] f_pc_r;
    logic        f_valid_r;
    logic [31:0] hold_inst_r;
    logic        hold_sel_r;

    logic [31:0] f_pc_s;
    logic        f_valid_s;
    logic [31:0] hold_inst_s;
    logic        hold_sel_s;

    // The IROM is addressed straight from pc so its data lines up with f_pc.
    assign bus.irom_addr = bus.pc[ADDR_W+1:2];

    assign bus.id_pc    = f_pc_r;
    assign bus.id_pc4   = f_pc_r + 32'd4;
    assign bus.id_valid = f_valid_r;

    // Instruction mux: bubbles show NOP, a held instruction wins over ROM data.
    always_comb begin
        bus.id_inst = NOP_INST;
        if (!f_valid_r) begin
            bus.id_inst = NOP_INST;
        end else if (hold_sel_r) begin
            bus.id_inst = hold_inst_r;
        end else begin
            bus.id_inst = bus.irom_rdata;
        end
    end

    // Next-state: flush beats stall; a stall captures the ROM word only once,
    // because on later stall cycles the ROM is already reading the next pc.
    always_comb begin
        f_pc_s      = f_pc_r;
        f_valid_s   = f_valid_r;
        hold_inst_s = hold_inst_r;
        hold_sel_s  = hold_sel_r;
        if (bus.flush) begin
            f_pc_s     = bus.pc;
            f_valid_s  = 1'b0;
            hold_sel_s = 1'b0;
        end else if (bus.stall) begin
            if (!hold_sel_r) begin
                hold_inst_s = bus.irom_rdata;
                hold_sel_s  = 1'b1;
            end else begin
                hold_inst_s = hold_inst_r;
                hold_sel_s  = hold_sel_r;
            end
        end else begin
            f_pc_s     = bus.pc;
            f_valid_s  = 1'b1;
            hold_sel_s = 1'b0;
        end
    end

    // Fetch-state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_r      <= RESET_PC;
            f_valid_r   <= 1'b0;
            hold_inst_r <= NOP_INST;
            hold_sel_r  <= 1'b0;
        end else begin
            f_pc_r      <= f_pc_s;
            f_valid_r   <= f_valid_s;
            hold_inst_r <= hold_inst_s;
            hold_sel_r  <= hold_sel_s;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_r;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_flush_r;

    // Performance counters; all wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_r <= 32'd0;
            perf_stall_r <= 32'd0;
            perf_flush_r <= 32'd0;
        end else begin
            if (bus.flush) begin
                perf_flush_r <= perf_flush_r + 32'd1;
            end else if (bus.stall) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_fetch_r <= perf_fetch_r + 32'd1;
            end
        end
    end

    assign perf_fetch = perf_fetch_r;
    assign perf_stall = perf_stall_r;
    assign perf_flush = perf_flush_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage. A small synchronous ROM model returns
// 0x1000_0000 + word address. Inputs are driven on the falling edge and the
// outputs are checked on the following falling edge, after the rising edge
// that consumed those inputs.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ROM_BASE = 32'h1000_0000;

    logic clk;
    logic rst;
    int   check_cnt;
    int   fail_cnt;

    if_fetch_stage_if #(.ADDR_W(14)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    if_fetch_stage #(
        .ADDR_W   (14),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_stall (perf_stall),
        .perf_flush (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous IROM model: one-cycle read latency.
    always_ff @(posedge clk) begin
        bus.irom_rdata <= ROM_BASE + {18'd0, bus.irom_addr};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic s, input logic f);
        bus.pc    = p;
        bus.stall = s;
        bus.flush = f;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc_e,
                             input logic [31:0] inst_e, input logic valid_e);
        check_eq({tag, "_pc"},    bus.id_pc,               pc_e);
        check_eq({tag, "_pc4"},   bus.id_pc4,              pc_e + 32'd4);
        check_eq({tag, "_inst"},  bus.id_inst,             inst_e);
        check_eq({tag, "_valid"}, {31'd0, bus.id_valid},   {31'd0, valid_e});
    endtask

    initial begin
        check_cnt = 0;
        fail_cnt  = 0;
        rst = 1'b1;
        drive(32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_out("reset", 32'h0, NOP, 1'b0);

        // First post-reset cycle is a bubble.
        rst = 1'b0;
        drive(32'h0, 1'b0, 1'b0);
        #1;
        check_eq("post_rst_bubble", {31'd0, bus.id_valid}, 32'd0);
        tick();
        check_out("run0", 32'h0, 32'h1000_0000, 1'b1);
        drive(32'h4, 1'b0, 1'b0);
        tick();
        check_out("run1", 32'h4, 32'h1000_0001, 1'b1);
        drive(32'h8, 1'b0, 1'b0);
        tick();
        check_out("run2", 32'h8, 32'h1000_0002, 1'b1);

        // Stall three cycles; the PC register holds 0xC meanwhile.
        for (int i = 0; i < 3; i++) begin
            drive(32'hC, 1'b1, 1'b0);
            tick();
            check_out($sformatf("stall%0d", i), 32'h8, 32'h1000_0002, 1'b1);
        end
        drive(32'hC, 1'b0, 1'b0);
        tick();
        check_out("unstall", 32'hC, 32'h1000_0003, 1'b1);
        drive(32'h10, 1'b0, 1'b0);
        tick();
        check_out("run4", 32'h10, 32'h1000_0004, 1'b1);

        // Flush with the PC register loading 0x40 at this edge.
        drive(32'h14, 1'b0, 1'b1);
        tick();
        check_out("flush_bub", 32'h14, NOP, 1'b0);
        drive(32'h40, 1'b0, 1'b0);
        tick();
        check_out("flush_tgt", 32'h40, 32'h1000_0010, 1'b1);

        // Stall to load the hold register, then flush+stall together.
        drive(32'h44, 1'b1, 1'b0);
        tick();
        check_out("pre_fs_hold", 32'h40, 32'h1000_0010, 1'b1);
        drive(32'h44, 1'b1, 1'b1);
        tick();
        check_out("fs_bub", 32'h44, NOP, 1'b0);
        drive(32'h80, 1'b0, 1'b0);
        tick();
        check_out("fs_tgt", 32'h80, 32'h1000_0020, 1'b1);

        // A bubble held under stall stays a bubble.
        drive(32'h84, 1'b0, 1'b1);
        tick();
        check_out("bub", 32'h84, NOP, 1'b0);
        drive(32'hC0, 1'b1, 1'b0);
        tick();
        check_out("bub_stall", 32'h84, NOP, 1'b0);
        drive(32'hC0, 1'b0, 1'b0);
        tick();
        check_out("bub_rel", 32'hC0, 32'h1000_0030, 1'b1);

        // Address mapping ignores pc[1:0]; wrap of pc+4.
        drive(32'h0000_0007, 1'b0, 1'b0);
        #1;
        check_eq("addr_lowbits", {18'd0, bus.irom_addr}, 32'h0000_0001);
        drive(32'hFFFF_FFFC, 1'b0, 1'b0);
        #1;
        check_eq("addr_wrap", {18'd0, bus.irom_addr}, 32'h0000_3FFF);
        tick();
        check_out("wrap", 32'hFFFF_FFFC, 32'h1000_3FFF, 1'b1);
        check_eq("wrap_pc4", bus.id_pc4, 32'h0000_0000);

        // Reset during a stall clears everything.
        drive(32'h0, 1'b1, 1'b0);
        tick();
        drive(32'h4, 1'b1, 1'b1);
        rst = 1'b1;
        tick();
        check_out("rst_mid", 32'h0, NOP, 1'b0);

`ifdef IF_PERF_CNT_EN
        check_eq("perf_rst_fetch", perf_fetch, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(32'h14, 1'b1, 1'b0);
            tick();
        end
        drive(32'h14, 1'b0, 1'b1);
        tick();
        check_eq("perf_fetch", perf_fetch, 32'd5);
        check_eq("perf_stall", perf_stall, 32'd3);
        check_eq("perf_flush", perf_flush, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Drives the synchronous instruction ROM (IROM) address from the current pc. Pairs the 1-cycle-late ROM data with the pc that requested it, and presents a valid {pc, pc+4, inst} bundle to the IF/ID consumer.
- Preserves the fetched instruction across hazard stalls and squashes it on branch/jump flush.

Parameters:
- ADDR_W, 14, IROM word-address width; irom_addr = pc[ADDR_W+1:2].
- RESET_PC, 32'h0000_0000, value of id_pc while reset is held.
- NOP_INST, 32'h0000_0013, instruction presented when id_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc  in  32  current PC from the PC register (held by that register during stall).
- stall  in  1  hazard stall from the hazard unit, same cycle it is applied to the PC register.
- flush  in  1  branch/jump redirect; squashes the in-flight fetch.
- irom_addr  out  ADDR_W  IROM word address, combinational from pc.
- irom_rdata  in  32  IROM data, valid the cycle after the address.
- id_pc  out  32  pc of the presented instruction.
- id_pc4  out  32  id_pc + 4, modulo 2^32.
- id_inst  out  32  presented instruction.
- id_valid  out  1  presented instruction is real (not a bubble).

Behaviour:
- Internal registers:
  - f_pc[31:0]: pc of the outstanding request.
  - f_valid.
  - hold_inst[31:0].
  - hold_sel: 0 selects ROM data; 1 selects hold_inst.
- Outputs:
  - id_pc = f_pc; id_valid = f_valid.
  - id_inst = !f_valid ? NOP_INST : (hold_sel ? hold_inst : irom_rdata).
  - id_pc4 = f_pc + 32'd4, wrapping.
- irom_addr = pc[ADDR_W+1:2], combinational, 0-cycle latency. pc[1:0] is ignored.
- Latency: pc presented in cycle t appears on id_pc/id_inst in cycle t+1.
- Sequential update, priority rst > flush > stall > normal:
  - rst=1: f_pc<=RESET_PC, f_valid<=0, hold_sel<=0, hold_inst<=NOP_INST.
  - flush=1: f_valid<=0, hold_sel<=0, f_pc<=pc.
    - Next cycle is exactly one bubble (id_inst=NOP_INST).
    - Flush overrides a simultaneous stall.
  - stall=1 with hold_sel=0: hold_inst<=irom_rdata, hold_sel<=1; f_pc and f_valid unchanged.
  - stall=1 with hold_sel=1: all state unchanged, for any stall length.
  - stall=0: f_pc<=pc, f_valid<=1, hold_sel<=0.
- During stall the PC register holds pc, so the IROM re-reads a stable address. The first unstalled cycle therefore returns correct data for the new f_pc with no extra bubble.
- First cycle after reset deassert: id_valid=0. The following cycle: id_valid=1, id_pc=pc value from the first post-reset cycle.
- A bubble (f_valid=0) held under stall stays a bubble; hold_inst is ignored while f_valid=0.
- Reset mid-stall or mid-flush: rst wins and clears all state in that cycle.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Three 32-bit wrapping counters, exported on outputs perf_fetch, perf_stall, perf_flush.
  - Each clears on rst.
  - perf_fetch increments each cycle with stall=0, flush=0, rst=0.
  - perf_stall increments each cycle with stall=1, flush=0.
  - perf_flush increments each cycle with flush=1.
- Undefined: the counters and the three ports do not exist.

Test Plan:
- Reset then run: rst=1 for 2 cycles, then pc=0,4,8 on successive cycles with IROM[k]=0x1000_0000+k -> id_valid 0 in the first post-reset cycle, then id_pc=0/4/8, id_inst=0x1000_0000/0x1000_0001/0x1000_0002, id_pc4=4/8/12.
- Stall hold: stall=1 for 3 cycles while id_pc=0x8 -> id_pc=0x8 and id_inst=0x1000_0002 for all 3 cycles plus the cycle stall falls. Next: id_pc=0xC, id_inst=0x1000_0003, no bubble.
- Flush: flush=1 while id_pc=0x10, with the PC register loading target 0x40 -> next cycle id_valid=0, id_inst=0x0000_0013. Cycle after: id_pc=0x40, id_valid=1.
- Flush+stall same cycle: both asserted -> flush behaviour; hold_sel cleared; one bubble; no stale hold_inst appears later.
- Wrap: pc=0xFFFF_FFFC -> id_pc4=0x0000_0000; irom_addr=pc[15:2]=0x3FFF.
- IF_PERF_CNT_EN defined: 5 normal, 3 stall, 1 flush cycle after reset -> perf_fetch=5, perf_stall=3, perf_flush=1.
